// File: rtl/gsim_mem_loader_pkg.sv
// rtl/gsim_mem_loader_pkg.sv - shared types, constants and address helpers for the matrix read loader
// Contents:
//   state_t   loader FSM encoding (IDLE, REQ, DRAIN, WAIT_REL, DONE)
//   row_t     FIFO entry: 256-bit row word plus its matrix and row tag
//   word_idx  fetch-order position -> row index (b first, then rows 0..15)
//   word_addr matrix index + fetch-order position -> memory word address
package gsim_mem_loader_pkg;

    localparam int WPM      = 17;
    localparam int B_OFFSET = 16;
    localparam int MEM_AW   = 10;
    localparam int ROW_W    = 256;
    localparam int TAG_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
        WAIT_REL,
        DONE
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] data;
        logic [TAG_W-1:0] mtx;
        logic [TAG_W-1:0] idx;
    } row_t;

    // The b word is fetched first so the engine has it before any row arrives.
    function automatic logic [TAG_W-1:0] word_idx(input logic [TAG_W-1:0] pos);
        return (pos == '0) ? TAG_W'(B_OFFSET) : pos - 1'b1;
    endfunction

    // Matrices are packed back to back, 17 words each: base = m*17 = m*16 + m.
    function automatic logic [MEM_AW-1:0] word_addr(input logic [TAG_W-1:0] m,
                                                     input logic [TAG_W-1:0] pos);
        logic [MEM_AW-1:0] base;
        base = ({5'd0, m} << 4) + {5'd0, m};
        return base + {5'd0, word_idx(pos)};
    endfunction

endpackage

// File: rtl/gsim_mem_loader_if.sv
// rtl/gsim_mem_loader_if.sv - control, memory read and row stream signals of the matrix loader
// Signals:
//   i_module_en, i_matrix_num        start pulse and matrix count
//   o_mem_rreq, o_mem_addr, i_mem_rrdy, i_mem_dout, i_mem_dout_vld   memory read port
//   o_row_vld, o_row_data, o_row_idx, o_row_mtx, i_row_rdy           row stream to engine
//   i_mtx_release, o_load_done       engine release pulse and completion pulse
// Modports: master = loader side, slave = environment (memory + engine) side.
interface gsim_mem_loader_if;
    import gsim_mem_loader_pkg::*;

    logic                i_module_en;
    logic [TAG_W-1:0]    i_matrix_num;
    logic                o_mem_rreq;
    logic [MEM_AW-1:0]   o_mem_addr;
    logic                i_mem_rrdy;
    logic [ROW_W-1:0]    i_mem_dout;
    logic                i_mem_dout_vld;
    logic                o_row_vld;
    logic [ROW_W-1:0]    o_row_data;
    logic [TAG_W-1:0]    o_row_idx;
    logic [TAG_W-1:0]    o_row_mtx;
    logic                i_row_rdy;
    logic                i_mtx_release;
    logic                o_load_done;

    modport master (
        input  i_module_en, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld,
               i_row_rdy, i_mtx_release,
        output o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_mtx,
               o_load_done
    );

    modport slave (
        output i_module_en, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld,
               i_row_rdy, i_mtx_release,
        input  o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_mtx,
               o_load_done
    );

endinterface

// File: rtl/gsim_rd_fifo.sv
// rtl/gsim_rd_fifo.sv - small synchronous FIFO holding returned row words with their tags
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset (clears contents)
//   push, push_data   write request; dropped when full unless a pop happens the same cycle
//   pop               read request; ignored when empty
//   head              oldest entry (registered storage, valid when count != 0)
//   count             number of entries held, 0..DEPTH
module gsim_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 266,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gsim_mem_loader.sv
// rtl/gsim_mem_loader.sv - read scheduler feeding matrix words from memory to the Gauss-Seidel engine
// Ports:
//   i_clk     clock
//   i_reset   asynchronous active-high reset; aborts any load in progress
//   bus       gsim_mem_loader_if.master: start/count, memory read port, row stream, release/done
// Each matrix is fetched as b (address base+16) followed by rows 0..15; reads are
// credit-limited so in-flight reads plus buffered words never exceed DEPTH.
module gsim_mem_loader
    import gsim_mem_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    gsim_mem_loader_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t           state;
    state_t           state_next;
    logic [TAG_W-1:0] n_lat;
    logic [TAG_W-1:0] m;
    logic [TAG_W-1:0] w;
    logic [TAG_W-1:0] ret_cnt;
    logic [TAG_W-1:0] pop_cnt;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      used;
    logic             credit_ok;
    logic             rel_flag;
    logic             accept;
    logic             rd_vld;
    logic             pop;
    logic             enter_req;
    row_t             push_row;
    row_t             head_row;

    assign accept    = bus.o_mem_rreq && bus.i_mem_rrdy;
    // Returns with nothing outstanding are stale (issued before a reset) and are dropped.
    assign rd_vld    = bus.i_mem_dout_vld && (outstanding != '0);
    assign pop       = bus.o_row_vld && bus.i_row_rdy;
    assign used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = used < (CW + 1)'(DEPTH);
    assign enter_req = (state_next == REQ) && (state != REQ);

    // Only one matrix is ever in flight, so the current m tags every returned word.
    assign push_row.data = bus.i_mem_dout;
    assign push_row.mtx  = m;
    assign push_row.idx  = word_idx(ret_cnt);

    gsim_rd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(row_t)),
        .CW    (CW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (rd_vld),
        .push_data (push_row),
        .pop       (pop),
        .head      (head_row),
        .count     (fifo_count)
    );

    assign bus.o_row_vld  = (fifo_count != '0);
    assign bus.o_row_data = bus.o_row_vld ? head_row.data : '0;
    assign bus.o_row_idx  = bus.o_row_vld ? head_row.idx  : '0;
    assign bus.o_row_mtx  = bus.o_row_vld ? head_row.mtx  : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        bus.o_mem_rreq  = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_load_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_module_en) begin
                    state_next = (bus.i_matrix_num == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                bus.o_mem_rreq = credit_ok;
                bus.o_mem_addr = word_addr(m, w);
                if (accept && (w == TAG_W'(WPM - 1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_cnt == TAG_W'(WPM)) begin
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (rel_flag) begin
                    state_next = (m == n_lat - 1'b1) ? DONE : REQ;
                end
            end
            DONE: begin
                bus.o_load_done = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            n_lat       <= '0;
            m           <= '0;
            w           <= '0;
            ret_cnt     <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
            rel_flag    <= 1'b0;
        end else begin
            if (state == IDLE && bus.i_module_en) begin
                n_lat <= bus.i_matrix_num;
                m     <= '0;
            end else if (state == WAIT_REL && state_next == REQ) begin
                m <= m + 1'b1;
            end

            if (enter_req) begin
                w       <= '0;
                ret_cnt <= '0;
                pop_cnt <= '0;
            end else begin
                if (accept) begin
                    w <= w + 1'b1;
                end
                if (rd_vld) begin
                    ret_cnt <= ret_cnt + 1'b1;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + 1'b1;
                end
            end

            case ({accept, rd_vld})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // The engine may finish early; remember the release until WAIT_REL consumes it.
            if (state == WAIT_REL && state_next != WAIT_REL) begin
                rel_flag <= 1'b0;
            end else if (bus.i_mtx_release &&
                         (state == REQ || state == DRAIN || state == WAIT_REL)) begin
                rel_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/gsim_mem_loader.md
Name: gsim_mem_loader

Overview:
- Read scheduler between the matrix memory and the Gauss-Seidel compute engine.
- Issues ordered read requests for each matrix's 17 words: b vector first, then A rows 0..15.
- Buffers returned 256-bit words in a small credit-controlled FIFO and hands them downstream with a valid/ready handshake.
- Sequences matrices 0..N-1, waiting for the engine to release each matrix before fetching the next.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum of outstanding reads plus buffered words.
- WPM, 17, words per matrix (16 A rows + 1 b word).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_module_en  in  1  start pulse; ignored unless in IDLE
- i_matrix_num  in  5  number of matrices N; latched at start
- o_mem_rreq  out  1  read request
- o_mem_addr  out  10  read word address
- i_mem_rrdy  in  1  memory accepts request this cycle
- i_mem_dout  in  256  read data
- i_mem_dout_vld  in  1  read data valid; returns in request order
- o_row_vld  out  1  row word available
- o_row_data  out  256  row word
- o_row_idx  out  5  0..15 = A row, 16 = b
- o_row_mtx  out  5  matrix index of o_row_data
- i_row_rdy  in  1  engine accepts row word
- i_mtx_release  in  1  pulse: engine finished with current matrix
- o_load_done  out  1  one-cycle pulse after last matrix released

Behaviour:
- Reset (already decided): reset i_reset, asynchronous, active-high; clock i_clk. All outputs 0; FSM in IDLE; counters and FIFO cleared. Reset mid-operation aborts everything. Data arriving after reset is dropped.
- FSM states: IDLE, REQ, DRAIN, WAIT_REL, DONE.
- IDLE: on i_module_en, latch N and set m=0.
  - N==0: go to DONE.
  - Otherwise: go to REQ with word counter w=0.
- REQ:
  - o_mem_rreq=1 when credit > 0, where credit = DEPTH - (outstanding + fifo_count).
  - Handshake completes when o_mem_rreq && i_mem_rrdy in the same cycle; only then increment w. Address and request are held stable until accepted.
  - Address: base = m*17 (10-bit unsigned, max 30*17+16=526).
    - w==0 → base+16 (b).
    - w=1..16 → base+(w-1) (row w-1).
  - After the 17th acceptance, go to DRAIN.
- Outstanding counter: +1 on accept, -1 on i_mem_dout_vld. Both in the same cycle → unchanged.
- i_mem_dout_vld pushes into the FIFO together with tag {m, idx}. idx follows the same order: 16, then 0..15.
  - Overflow is impossible by credit. If vld arrives with the FIFO full (protocol violation), drop the word and keep count saturated.
- FIFO head drives o_row_vld/data/idx/mtx. Pop on o_row_vld && i_row_rdy.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Combinational first-word fall-through is not required; output is registered. Latency from i_mem_dout_vld to o_row_vld is 1 cycle.
- DRAIN: wait until all 17 words of matrix m have been popped, then go to WAIT_REL.
- i_mtx_release: latched into a sticky flag whenever it arrives in REQ, DRAIN or WAIT_REL; cleared on leaving WAIT_REL.
- WAIT_REL: with the flag set:
  - m==N-1 → DONE.
  - Otherwise → m+1, w=0, go to REQ.
- DONE: o_load_done=1 for one cycle, then IDLE.
- i_module_en outside IDLE: ignored.
- No request is ever issued for matrix m+1 before matrix m is released. This keeps the engine's row memory single-buffered.

Decomposition:
- Shared package/define file: state encodings (IDLE..DONE), WPM=17, B_OFFSET=16, MEM_AW=10, ROW_W=256.
- Sub-module gsim_rd_fifo: parameterised DEPTH × (256+5+5) synchronous FIFO with count output, async reset, simultaneous push/pop support. Credit logic stays in the loader.

Test Plan:
- N=1, i_mem_rrdy=1, 2-cycle read latency, i_row_rdy=1 → addresses 16,0,1,...,15; o_row_idx 16,0..15 with o_row_mtx=0; after i_mtx_release, o_load_done pulses once.
- N=2, release pulse for matrix 0 sent during DRAIN → sticky; matrix 1 addresses 33,17..32 issued; no address ≥17 is requested before the release.
- i_row_rdy=0 for 20 cycles with DEPTH=4 → at most 4 requests accepted; o_mem_rreq drops to 0. When rdy returns, remaining 13 words delivered in order with no loss.
- i_mem_rrdy toggling 1,0,0,1 → o_mem_addr stable while rreq is high and not accepted; w advances only on accept.
- i_matrix_num=0 with i_module_en → no o_mem_rreq; o_load_done pulses 1 cycle after start.
- Assert i_reset during REQ of matrix 1 with 3 reads outstanding → all outputs 0 immediately, FIFO empty. A subsequent start with N=1 fetches address 16 first.
